// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester and transmitter signals that pass through uart_tx_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// requesters and transmitter around it.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW    = $clog2(NREQ);
  localparam int DATA_W = 8;

  // Requester side
  logic [NREQ-1:0]        req;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [IDW-1:0]         grant_id;
  logic                   busy;

  // Transmitter side
  logic                   tx_write;
  logic [DATA_W-1:0]      tx_data;
  logic                   txrdy;

  // Status
  logic                   timeout_err;

  modport master (
    input  req, req_data, txrdy,
    output ack, grant_id, busy, tx_write, tx_data, timeout_err
  );

  modport slave (
    output req, req_data, txrdy,
    input  ack, grant_id, busy, tx_write, tx_data, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ
// byte producers. A byte is granted only when the transmitter is idle. Further
// grants are held off until the transmitter has taken the byte (txrdy falls)
// and finished the frame (txrdy rises again).
//
// Optional feature, enabled by defining the macro UART_ARB_TIMEOUT_EN: a
// watchdog in WAIT_START that gives up after TIMEOUT cycles if the transmitter
// never drops txrdy. It raises a sticky timeout_err and returns to IDLE.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               mclkx16,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);
  localparam int DATA_W = 8;
  localparam int IDW    = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Arbitration
  logic [IDW-1:0]      r_last;
  logic [IDW-1:0]      w_idx;
  logic [IDW-1:0]      w_winner;
  logic                w_found;
  logic                w_grant;
  logic [DATA_W-1:0]   w_data_sel;

  // Next values of the registered outputs
  logic                w_tx_write_nxt;
  logic [NREQ-1:0]     w_ack_nxt;
  logic                w_busy_nxt;

  // Registered outputs
  logic                r_tx_write;
  logic [DATA_W-1:0]   r_tx_data;
  logic [NREQ-1:0]     r_ack;
  logic [IDW-1:0]      r_grant_id;
  logic                r_busy;

  // Watchdog hit in WAIT_START. It stays 0 when the watchdog is compiled out.
  logic                w_cnt_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_timeout_err;

  // The watchdog fires on the cycle in which the count would reach TIMEOUT.
  // With the count at 0 on the grant edge, that is TIMEOUT edges after the
  // tx_write pulse.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_hit = (r_state == S_WAIT_START) && bus.txrdy &&
                     (w_cnt_inc == CNT_W'(TIMEOUT));

  // Watchdog counter: cleared by a grant, counts cycles spent in WAIT_START.
  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_START) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_cnt_hit) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  // Without the watchdog, WAIT_START waits for the transmitter indefinitely.
  logic                w_unused_timeout;

  assign w_cnt_hit        = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign bus.timeout_err  = 1'b0;
`endif

  // Round-robin search: first pending requester after the previous winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // A grant happens only from IDLE, with the transmitter idle.
  assign w_grant    = (r_state == S_IDLE) && bus.txrdy && w_found;
  assign w_data_sel = bus.req_data[int'(w_winner)*DATA_W +: DATA_W];

  // State register.
  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Changes on req outside IDLE have no effect here.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (!bus.txrdy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_cnt_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.txrdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: one-cycle write/ack pulses on a grant, busy tracks the next state.
  always_comb begin
    w_tx_write_nxt = w_grant;
    w_ack_nxt      = '0;
    if (w_grant) begin
      w_ack_nxt[w_winner] = 1'b1;
    end
    w_busy_nxt     = (w_state_nxt != S_IDLE);
  end

  // Output and arbitration registers. tx_data and grant_id hold until the next grant.
  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_tx_write <= 1'b0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_last     <= IDW'(NREQ - 1);
    end else begin
      r_tx_write <= w_tx_write_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      if (w_grant) begin
        r_tx_data  <= w_data_sel;
        r_grant_id <= w_winner;
        r_last     <= w_winner;
      end
    end
  end

  assign bus.tx_write = r_tx_write;
  assign bus.tx_data  = r_tx_data;
  assign bus.ack      = r_ack;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. The bench itself plays the requesters and the
// transmitter. The expected winner comes from a forward-distance round-robin
// model kept here.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic mclkx16 = 1'b0;
  logic reset   = 1'b0;

  always #5 mclkx16 = ~mclkx16;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .mclkx16 (mclkx16),
    .reset   (reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int ref_last = NREQ - 1;
  int wr_pulses = 0;
  int ack_pulses = 0;
  logic [7:0] bytes [NREQ];

  // Passive pulse counters, sampled mid-cycle.
  always @(negedge mclkx16) begin
    if (bus.tx_write === 1'b1) wr_pulses++;
    if (bus.ack !== '0) ack_pulses++;
  end

  // Reference: the winner is the pending requester with the smallest forward
  // distance (1..NREQ) from the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        d = (i - last + NREQ) % NREQ;
        if (d == 0) d = NREQ;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge mclkx16);
    #1;
  endtask

  task automatic set_req(input logic [NREQ-1:0] mask);
    bus.req = mask;
    for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = bytes[i];
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    ref_last = NREQ - 1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_write(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (bus.tx_write === 1'b1) seen = 1'b1;
    end
  endtask

  // Transmitter model: accept the byte after 'accept' cycles, send for 'len' cycles.
  task automatic frame(input int accept, input int len);
    repeat (accept) tick();
    bus.txrdy = 1'b0;
    repeat (len) tick();
    bus.txrdy = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_data = '0; bus.txrdy = 1'b0;
    reset = 1'b0;
    tick();
    n_vec++; if (bus.tx_write !== 1'b0) begin n_err++; $display("FAIL rst_tx_write got %b want 0", bus.tx_write); end
    n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
    n_vec++; if (bus.ack !== '0) begin n_err++; $display("FAIL rst_ack got %b want 0", bus.ack); end
    n_vec++; if (bus.grant_id !== '0) begin n_err++; $display("FAIL rst_grant_id got %0d want 0", bus.grant_id); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err got %b want 0", bus.timeout_err); end
    reset = 1'b1;
    ref_last = NREQ - 1;
    bus.txrdy = 1'b1;
    begin
      int w0;
      w0 = wr_pulses;
      repeat (5) tick();
      n_vec++; if (wr_pulses != w0) begin n_err++; $display("FAIL idle_noreq writes got %0d want 0", wr_pulses - w0); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_noreq_busy got %b want 0", bus.busy); end
    end
  endtask

  task automatic test_single();
    bytes[0] = 8'hA5;
    set_req(4'b0001);
    tick();
    n_vec++; if (bus.tx_write !== 1'b1) begin n_err++; $display("FAIL single_tx_write got %b want 1", bus.tx_write); end
    n_vec++; if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data got %h want a5", bus.tx_data); end
    n_vec++; if (bus.ack !== 4'b0001) begin n_err++; $display("FAIL single_ack got %b want 0001", bus.ack); end
    n_vec++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL single_grant_id got %0d want 0", bus.grant_id); end
    ref_last = 0;
    set_req(4'b0000);
    tick();
    n_vec++; if (bus.tx_write !== 1'b0 || bus.ack !== '0) begin n_err++; $display("FAIL single_pulse_width write %b ack %b want 0/0000", bus.tx_write, bus.ack); end
    tick();
    bus.txrdy = 1'b0;
    repeat (20) tick();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_frame got %b want 1", bus.busy); end
    bus.txrdy = 1'b1;
    tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done got %b want 0", bus.busy); end
    n_vec++; if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold got %h want a5", bus.tx_data); end
  endtask

  task automatic test_fairness();
    bit seen;
    int exp;
    int w0, a0;
    apply_reset();
    bus.txrdy = 1'b1;
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
    set_req('1);
    w0 = wr_pulses; a0 = ack_pulses;
    for (int g = 0; g < 6; g++) begin
      wait_write(8, seen);
      n_vec++;
      if (!seen) begin
        n_err++; $display("FAIL fair_grant%0d no tx_write within budget", g);
      end else begin
        exp = rr_pick(bus.req, ref_last);
        n_vec++; if (int'(bus.grant_id) !== exp) begin n_err++; $display("FAIL fair_id%0d got %0d want %0d", g, bus.grant_id, exp); end
        n_vec++; if (bus.ack !== onehot(exp)) begin n_err++; $display("FAIL fair_ack%0d got %b want %b", g, bus.ack, onehot(exp)); end
        n_vec++; if (bus.tx_data !== bytes[exp]) begin n_err++; $display("FAIL fair_data%0d got %h want %h", g, bus.tx_data, bytes[exp]); end
        ref_last = exp;
        bytes[exp] = 8'($urandom);
        set_req('1);
      end
      frame(2, 160);
    end
    n_vec++; if (wr_pulses - w0 != 6) begin n_err++; $display("FAIL fair_write_count got %0d want 6", wr_pulses - w0); end
    n_vec++; if (ack_pulses - a0 != 6) begin n_err++; $display("FAIL fair_ack_count got %0d want 6", ack_pulses - a0); end
  endtask

  task automatic test_skip();
    bit seen;
    int exp;
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
    set_req(4'b1010);
    for (int g = 0; g < 2; g++) begin
      wait_write(8, seen);
      n_vec++;
      if (!seen) begin
        n_err++; $display("FAIL skip_grant%0d no tx_write within budget", g);
      end else begin
        exp = rr_pick(bus.req, ref_last);
        n_vec++; if (int'(bus.grant_id) !== exp) begin n_err++; $display("FAIL skip_id%0d got %0d want %0d", g, bus.grant_id, exp); end
        n_vec++; if (bus.tx_data !== bytes[exp]) begin n_err++; $display("FAIL skip_data%0d got %h want %h", g, bus.tx_data, bytes[exp]); end
        ref_last = exp;
      end
      if (g == 1) set_req('0);
      frame(1, 20);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    bus.txrdy = 1'b0;
    bytes[2] = 8'($urandom);
    set_req(4'b0100);
    w0 = wr_pulses;
    repeat (50) tick();
    n_vec++; if (wr_pulses != w0) begin n_err++; $display("FAIL bp_no_write got %0d writes want 0", wr_pulses - w0); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_busy got %b want 0", bus.busy); end
    bus.txrdy = 1'b1;
    tick();
    n_vec++; if (bus.tx_write !== 1'b1) begin n_err++; $display("FAIL bp_write got %b want 1", bus.tx_write); end
    n_vec++; if (bus.grant_id !== 2'd2 || bus.ack !== 4'b0100) begin n_err++; $display("FAIL bp_grant id %0d ack %b want 2/0100", bus.grant_id, bus.ack); end
    n_vec++; if (bus.tx_data !== bytes[2]) begin n_err++; $display("FAIL bp_data got %h want %h", bus.tx_data, bytes[2]); end
    ref_last = 2;
    set_req('0);
    frame(2, 30);
  endtask

  task automatic test_random();
    bit seen;
    int exp;
    logic [NREQ-1:0] mask;
    int w0;
    for (int it = 0; it < 40; it++) begin
      mask = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
      set_req(mask);
      exp = rr_pick(mask, ref_last);
      if (exp < 0) begin
        w0 = wr_pulses;
        repeat (3) tick();
        n_vec++; if (wr_pulses != w0) begin n_err++; $display("FAIL rand%0d_noreq writes %0d want 0", it, wr_pulses - w0); end
      end else begin
        wait_write(5, seen);
        n_vec++;
        if (!seen) begin
          n_err++; $display("FAIL rand%0d no tx_write for req %b", it, mask);
        end else begin
          n_vec++; if (int'(bus.grant_id) !== exp || bus.ack !== onehot(exp)) begin n_err++; $display("FAIL rand%0d_id req %b got %0d/%b want %0d", it, mask, bus.grant_id, bus.ack, exp); end
          n_vec++; if (bus.tx_data !== bytes[exp]) begin n_err++; $display("FAIL rand%0d_data got %h want %h", it, bus.tx_data, bytes[exp]); end
          ref_last = exp;
        end
        set_req('0);
        frame(int'($urandom_range(1, 4)), int'($urandom_range(8, 40)));
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.txrdy = 1'b1;
    bytes[0] = 8'h3C;
    set_req(4'b0001);
    tick();
    n_vec++; if (bus.tx_write !== 1'b1) begin n_err++; $display("FAIL to_write got %b want 1", bus.tx_write); end
    ref_last = 0;
    set_req('0);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    n_vec++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early busy %b err %b want 1/0", bus.busy, bus.timeout_err); end
    tick();
    n_vec++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_fire busy %b err %b want 0/1", bus.busy, bus.timeout_err); end
    bytes[1] = 8'h96;
    set_req(4'b0010);
    tick();
    n_vec++; if (bus.tx_write !== 1'b1 || bus.grant_id !== 2'd1) begin n_err++; $display("FAIL to_resume write %b id %0d want 1/1", bus.tx_write, bus.grant_id); end
    n_vec++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", bus.timeout_err); end
    ref_last = 1;
    set_req('0);
    frame(2, 20);
`else
    repeat (TIMEOUT + 36) tick();
    n_vec++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_disabled busy %b err %b want 1/0", bus.busy, bus.timeout_err); end
    frame(0, 4);
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    bus.txrdy = 1'b1;
    bytes[2] = 8'h5A;
    set_req(4'b0100);
    tick();
    n_vec++; if (bus.grant_id !== 2'd2 || bus.tx_data !== 8'h5A) begin n_err++; $display("FAIL rm_grant id %0d data %h want 2/5a", bus.grant_id, bus.tx_data); end
    set_req('0);
    tick();
    bus.txrdy = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_before got %b want 1", bus.busy); end
    #3;
    reset = 1'b0;
    #1;
    ok = (bus.tx_write === 1'b0) && (bus.tx_data === 8'h00) && (bus.ack === '0) &&
         (bus.grant_id === '0) && (bus.busy === 1'b0) && (bus.timeout_err === 1'b0);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rm_async wr %b data %h ack %b id %0d busy %b err %b want all 0", bus.tx_write, bus.tx_data, bus.ack, bus.grant_id, bus.busy, bus.timeout_err); end
    ref_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
    set_req('1);
    bus.txrdy = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.tx_write !== 1'b0) begin n_err++; $display("FAIL rm_held got write %b want 0", bus.tx_write); end
    reset = 1'b1;
    tick();
    n_vec++; if (bus.tx_write !== 1'b1 || bus.grant_id !== 2'd0 || bus.ack !== 4'b0001) begin n_err++; $display("FAIL rm_first write %b id %0d ack %b want 1/0/0001", bus.tx_write, bus.grant_id, bus.ack); end
    n_vec++; if (bus.tx_data !== bytes[0]) begin n_err++; $display("FAIL rm_first_data got %h want %h", bus.tx_data, bytes[0]); end
    ref_last = 0;
    set_req('0);
    frame(2, 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) bytes[i] = 8'h00;
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among up to `NREQ` byte-producing requesters. It sits between the requesters and the transmitter's `write`/`datain`/`txrdy` handshake and grants one byte at a time. It then holds off further grants until the transmitter has accepted the byte and finished sending it. Optionally, it detects a transmitter that never accepts a written byte.

## Interface

Parameters:
- `NREQ`, default 4. Number of requesters, range 2..8.
- `TIMEOUT`, default 64. Number of `mclkx16` cycles to wait for `txrdy` to fall after a write. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `mclkx16`  in  1  Single clock, the 16x baud master clock.
- `reset`  in  1  Asynchronous, active-low reset.
- `req`  in  NREQ  Per-requester byte-pending flag. The requester holds it high until its `ack`.
- `req_data`  in  8*NREQ  Requester i's byte is on `[8i+7:8i]`. It must be stable while `req[i]` is high.
- `ack`  out  NREQ  One-hot, single-cycle pulse. Marks the cycle in which the requester's byte is written.
- `grant_id`  out  $clog2(NREQ)  Index of the most recent grant.
- `busy`  out  1  High whenever the FSM is not in IDLE.
- `tx_write`  out  1  Drives the transmitter's `write` input. Single-cycle pulse.
- `tx_data`  out  8  Drives the transmitter's `datain` input.
- `txrdy`  in  1  Transmitter ready/idle flag.
- `timeout_err`  out  1  Sticky timeout flag. Constant 0 without `UART_ARB_TIMEOUT_EN`.

## Operation

- FSM states are IDLE, WAIT_START and WAIT_DONE.
- **IDLE**
  - If `txrdy`=1 and any `req` bit is set, choose the winner by round-robin. The search starts at `(last+1) mod NREQ` and takes the first set bit.
  - On the grant, register `tx_data <= req_data[winner]`, pulse `tx_write` and `ack[winner]`, set `grant_id` and `last` to the winner, and go to WAIT_START.
  - If `txrdy`=0, no grant is made. This covers a transmitter still busy after reset or a frame in flight.
- **WAIT_START**
  - Wait for `txrdy`=0, meaning the transmitter has accepted the byte, then go to WAIT_DONE.
  - With `UART_ARB_TIMEOUT_EN`, a counter runs in this state. The timeout case is described under Configuration.
- **WAIT_DONE**
  - Wait for `txrdy`=1, then go to IDLE.
- `busy` = (state != IDLE).
- `tx_data` holds the last granted byte until the next grant.
- `req` changes in WAIT_START or WAIT_DONE are ignored. They are re-evaluated in IDLE.
- Reset values:
  - state IDLE
  - `last` = NREQ-1, so requester 0 wins first after reset
  - `tx_write`=0, `tx_data`=8'h00, `ack`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, timeout counter 0.
- Reset mid-operation:
  - All of the above take effect immediately, without waiting for a clock edge.
  - A frame already in the transmitter is not this block's concern.
  - After reset release the block re-grants only once `txrdy`=1.
- No requests while in IDLE: the block stays in IDLE with all pulses low.

## Timing

- All outputs are registered.
- Grant latency: `req[i]` and `txrdy` are sampled high at edge N. `tx_write`, `ack[i]`, `tx_data` and `grant_id` are valid from edge N until edge N+1.
- `tx_write` and `ack` are high for exactly one cycle per grant, and in the same cycle.
- IDLE to WAIT_START takes 1 cycle.
- The WAIT_START and WAIT_DONE durations are set by the transmitter's `txrdy`.
- The WAIT_DONE to IDLE transition happens on the edge that samples `txrdy`=1. The next grant can occur on the following edge.
- The minimum gap between successive `tx_write` pulses is 3 cycles plus the frame time.
- Requester i may change `req_data` or deassert `req[i]` in the cycle after `ack[i]`.

## Configuration

- Macro: `UART_ARB_TIMEOUT_EN`.
- When defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT_START and increments each cycle spent there.
  - If `txrdy` is still 1 when the counter reaches `TIMEOUT`, the block sets `timeout_err`=1 and returns to IDLE.
  - `timeout_err` is sticky and is cleared only by `reset`.
  - Arbitration continues normally after a timeout.
- When not defined:
  - There is no counter logic.
  - `timeout_err` is tied to 0.
  - WAIT_START waits indefinitely.

## Test plan

- Single request: `req`=0001, `req_data[7:0]`=8'hA5, `txrdy`=1. Next edge: `tx_write`=1, `tx_data`=8'hA5, `ack`=0001, `grant_id`=0, each for one cycle. `busy` stays high until the transmitter model lowers and then raises `txrdy`.
- Fairness: `req`=1111 held, with a transmitter model returning `txrdy` after 160 cycles. Grant order is 0,1,2,3,0,1. Each `ack` pulses once per frame.
- Skip idle requesters: after a grant to 1, hold `req`=1010. The next grant goes to 3, then 1.
- Back-pressure: `req`=0100 while `txrdy`=0 for 50 cycles. No `tx_write` is issued. The grant to 2 occurs on the edge after `txrdy` rises.
- Timeout, with `UART_ARB_TIMEOUT_EN` and `TIMEOUT`=64: after a grant, `txrdy` is stuck at 1.
  - `timeout_err`=1 and `busy`=0 exactly 64 cycles after the `tx_write` pulse.
  - Without the macro, `busy` stays 1 and `timeout_err` stays 0.
- Reset in WAIT_DONE: assert `reset`=0 between clock edges.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release with `req`=1111 and `txrdy`=1, the first grant goes to requester 0.
